// File: rtl/conv_out_buffer.sv
// conv_out_buffer
//   Output stage behind the conv MAC pipeline. Each y[k] accepted on the
//   in_* handshake has optional ReLU applied, is saturated to OUT_WIDTH and
//   is stored in a DEPTH-entry FIFO. The FIFO head drives the m_* master port.
//   The last y of a convolution is flagged on m_last. frame_done pulses for
//   one cycle once that last sample has been taken downstream.
//
// Ports
//   clk, reset        clock (rising edge), synchronous active-high reset
//   in_data/valid     signed accumulator result from the MAC pipeline
//   in_ready          buffer can take in_data this cycle (never looks at in_valid)
//   m_data/valid      signed saturated sample at the FIFO head
//   m_ready           downstream takes m_data
//   m_last            head is the final y of the current convolution
//   frame_done        1-cycle pulse after the last y has been popped
//   fill_level        entries currently held (0..DEPTH)
//   sat_event         1-cycle pulse: the sample written on the previous edge was clipped
module conv_out_buffer #(
  parameter int ACC_WIDTH = 20,
  parameter int OUT_WIDTH = 12,
  parameter int DEPTH     = 4,
  parameter int X_SIZE    = 128,
  parameter int F_SIZE    = 32,
  parameter bit RELU_EN   = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [ACC_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic signed [OUT_WIDTH-1:0] m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        m_last,
  output logic                        frame_done,
  output logic [$clog2(DEPTH):0]      fill_level,
  output logic                        sat_event
);

  localparam int Y_SIZE = X_SIZE - F_SIZE + 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(Y_SIZE - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  // Saturation bounds expressed at accumulator width; min is the bitwise
  // complement of max in two's complement.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2**(OUT_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        in_cnt, out_cnt;
  logic                 push, pop, full;

  logic signed [ACC_WIDTH-1:0] relu_v;
  logic [OUT_WIDTH-1:0]        conv_v;
  logic                        clip;

  assign full    = (fill_level == FULL_LVL);
  assign m_valid = (fill_level != '0);
  assign m_data  = $signed(mem[rd_ptr]);
  assign m_last  = m_valid && (out_cnt == LAST_IDX);
  assign push    = in_valid && in_ready;
  assign pop     = m_valid && m_ready;

  // ReLU first, then clip to the output range.
  always_comb begin
    relu_v = (RELU_EN && (in_data < 0)) ? '0 : in_data;
    conv_v = relu_v[OUT_WIDTH-1:0];
    clip   = 1'b0;
    if (relu_v > SAT_MAX) begin
      conv_v = SAT_MAX[OUT_WIDTH-1:0];
      clip   = 1'b1;
    end else if (relu_v < SAT_MIN) begin
      conv_v = SAT_MIN[OUT_WIDTH-1:0];
      clip   = 1'b1;
    end
  end

  // FIFO storage: no reset needed, validity is tracked by fill_level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= conv_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill_level <= '0;
      sat_event  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill_level <= fill_level + 1'b1;
        2'b01:   fill_level <= fill_level - 1'b1;
        default: fill_level <= fill_level;
      endcase
      sat_event <= push && clip;
    end
  end

  // Per-frame position counters; they saturate at the last index and are
  // cleared in DONE so the next frame starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else if (state == DONE) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (push && (in_cnt != LAST_IDX))  in_cnt  <= in_cnt + 1'b1;
      if (pop  && (out_cnt != LAST_IDX)) out_cnt <= out_cnt + 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (push && (in_cnt == LAST_IDX)) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last)                state_nxt = DONE;
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM: outputs. Full blocks pushes even if a pop happens in the same cycle.
  always_comb begin
    in_ready   = (state == RUN) && !full;
    frame_done = (state == DONE);
  end

endmodule
